// File: rtl/beam_pkg.sv
// Shared types for the beam phase sequencer: FSM encoding, Q9.7 word, phase index width.
package beam_pkg;

  localparam int unsigned PHASE_IDX_W = 6;

  typedef logic [15:0] q9_7_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_FLUSH
  } seq_state_e;

endpackage

// File: rtl/beam_phase_seq.sv
// Beam phase sequencer: accepts one beam command, streams element coordinates to the
// phase calculator one per cycle, collects returned phase indices in order into the
// result memory, and handles abort, drain timeout and in-flight result flushing.
module beam_phase_seq
  import beam_pkg::*;
#(
  parameter int unsigned N_ELEM      = 64,
  parameter int unsigned ADDR_W      = $clog2(N_ELEM),
  parameter int unsigned PC_LAT      = 32,
  parameter int unsigned TIMEOUT_CYC = PC_LAT + 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [15:0]            cmd_az_deg,
  input  logic [15:0]            cmd_el_deg,
  input  logic                   cmd_is_tx,
  input  logic [ADDR_W:0]        cmd_n_elem,
  input  logic                   abort,
  output logic                   coord_rd,
  output logic [ADDR_W-1:0]      coord_addr,
  input  logic [15:0]            coord_x,
  input  logic [15:0]            coord_y,
  output logic                   pc_start,
  output logic                   pc_is_tx,
  output logic [15:0]            pc_az,
  output logic [15:0]            pc_el,
  output logic [15:0]            pc_x,
  output logic [15:0]            pc_y,
  input  logic                   pc_valid,
  input  logic [PHASE_IDX_W-1:0] pc_phase_idx,
  output logic                   res_we,
  output logic [ADDR_W-1:0]      res_addr,
  output logic [PHASE_IDX_W-1:0] res_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned GAP_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned FLUSH_W = $clog2(PC_LAT + 3);

  localparam logic [CNT_W-1:0]   N_MAX     = CNT_W'(N_ELEM);
  localparam logic [GAP_W-1:0]   GAP_LIMIT = GAP_W'(TIMEOUT_CYC);
  localparam logic [FLUSH_W-1:0] FLUSH_END = FLUSH_W'(PC_LAT + 1);

  seq_state_e state, state_nx;

  logic [CNT_W-1:0]   n_lat;
  logic [CNT_W-1:0]   n_sat;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   ret_cnt;
  logic [CNT_W-1:0]   outstanding;
  logic [GAP_W-1:0]   gap_cnt;
  logic [FLUSH_W-1:0] flush_cnt;
  logic               done_phase;

  logic               accept;
  logic               active;
  logic               abort_hit;
  logic               ret_ok;
  logic               last_ret;
  logic               issue_last;
  logic               gap_hit;
  logic               flush_last;

  q9_7_t              az_q;
  q9_7_t              el_q;

  assign n_sat      = (cmd_n_elem > N_MAX) ? N_MAX : cmd_n_elem;
  assign accept     = (state == S_IDLE) && cmd_valid;
  assign active     = (state == S_ISSUE) || (state == S_DRAIN);
  assign abort_hit  = active && abort;
  // A return is only taken while something is in flight and the beam has not been aborted;
  // an abort in the same cycle as a return therefore suppresses that return's write.
  assign ret_ok     = active && pc_valid && (outstanding != '0) && !abort;
  assign last_ret   = ret_ok && (state == S_DRAIN) && (ret_cnt == n_lat - CNT_W'(1));
  assign issue_last = (issue_cnt == n_lat - CNT_W'(1));
  assign gap_hit    = (state == S_DRAIN) && (gap_cnt == GAP_LIMIT);
  assign flush_last = (flush_cnt == FLUSH_END);

  assign pc_x  = coord_x;
  assign pc_y  = coord_y;
  assign pc_az = az_q;
  assign pc_el = el_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state selection; abort has priority over completion and timeout
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = (n_sat == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (abort)           state_nx = S_FLUSH;
        else if (issue_last) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)         state_nx = S_FLUSH;
        else if (last_ret) state_nx = S_DONE;
        else if (gap_hit)  state_nx = S_FLUSH;
      end
      S_DONE: begin
        if (done_phase) state_nx = S_IDLE;
      end
      S_FLUSH: begin
        if (flush_last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready  = (state == S_IDLE);
    busy       = (state != S_IDLE);
    coord_rd   = (state == S_ISSUE);
    coord_addr = '0;
    done       = (state == S_DONE) && done_phase;
    if (state == S_ISSUE) coord_addr = issue_cnt[ADDR_W-1:0];
  end

  // Command fields held for the whole beam
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      az_q     <= '0;
      el_q     <= '0;
      pc_is_tx <= 1'b0;
      n_lat    <= '0;
    end else if (accept) begin
      az_q     <= cmd_az_deg;
      el_q     <= cmd_el_deg;
      pc_is_tx <= cmd_is_tx;
      n_lat    <= n_sat;
    end
  end

  // Issue side: table read index and the calculator start, one cycle behind the read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
      pc_start  <= 1'b0;
    end else begin
      pc_start <= (state == S_ISSUE) && !abort;
      if (accept)                issue_cnt <= '0;
      else if (state == S_ISSUE) issue_cnt <= issue_cnt + CNT_W'(1);
    end
  end

  // Return side: in-flight count, in-order result writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      ret_cnt     <= '0;
      res_we      <= 1'b0;
      res_addr    <= '0;
      res_idx     <= '0;
    end else begin
      res_we <= ret_ok;
      if (ret_ok) begin
        res_addr <= ret_cnt[ADDR_W-1:0];
        res_idx  <= pc_phase_idx;
      end
      if (accept)      ret_cnt <= '0;
      else if (ret_ok) ret_cnt <= ret_cnt + CNT_W'(1);
      if (active && !abort_hit) outstanding <= outstanding + CNT_W'(pc_start) - CNT_W'(ret_ok);
      else                      outstanding <= '0;
    end
  end

  // Drain watchdog: cycles since the last accepted return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= gap_hit && !abort && !last_ret;
      if (state != S_DRAIN) gap_cnt <= '0;
      else if (ret_ok)      gap_cnt <= '0;
      else                  gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  // Flush dwell and the two-cycle DONE sequence (done asserts in its second cycle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt  <= '0;
      done_phase <= 1'b0;
    end else begin
      done_phase <= (state == S_DONE) && !done_phase;
      if (state == S_FLUSH) flush_cnt <= flush_cnt + FLUSH_W'(1);
      else                  flush_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_beam_phase_seq.sv
// Directed bench for beam_phase_seq with a coordinate table model and a fixed-latency
// phase calculator model (optional dropped result, optional spurious valid).
module tb_beam_phase_seq;

  localparam int N_ELEM      = 64;
  localparam int ADDR_W      = 6;
  localparam int PC_LAT      = 32;
  localparam int TIMEOUT_CYC = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [15:0]       cmd_az_deg = '0;
  logic [15:0]       cmd_el_deg = '0;
  logic              cmd_is_tx = 1'b0;
  logic [ADDR_W:0]   cmd_n_elem = '0;
  logic              abort = 1'b0;
  logic              coord_rd;
  logic [ADDR_W-1:0] coord_addr;
  logic [15:0]       coord_x = '0;
  logic [15:0]       coord_y = '0;
  logic              pc_start, pc_is_tx;
  logic [15:0]       pc_az, pc_el, pc_x, pc_y;
  logic              pc_valid;
  logic [5:0]        pc_phase_idx;
  logic              res_we;
  logic [ADDR_W-1:0] res_addr;
  logic [5:0]        res_idx;
  logic              busy, done, err_timeout;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;

  logic spur_v = 1'b0;
  int   drop_k = 0;

  int rd_n, rd_first, rd_last, rd_bad;
  int st_n, st_first, st_last, st_bad;
  int we_n, we_last, done_n, done_cyc, err_n, err_cyc;
  logic [5:0]  res_mem [64];
  logic [63:0] res_mask;

  beam_phase_seq #(
    .N_ELEM(N_ELEM), .ADDR_W(ADDR_W), .PC_LAT(PC_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_az_deg(cmd_az_deg), .cmd_el_deg(cmd_el_deg), .cmd_is_tx(cmd_is_tx),
    .cmd_n_elem(cmd_n_elem), .abort(abort), .coord_rd(coord_rd), .coord_addr(coord_addr),
    .coord_x(coord_x), .coord_y(coord_y), .pc_start(pc_start), .pc_is_tx(pc_is_tx),
    .pc_az(pc_az), .pc_el(pc_el), .pc_x(pc_x), .pc_y(pc_y), .pc_valid(pc_valid),
    .pc_phase_idx(pc_phase_idx), .res_we(res_we), .res_addr(res_addr), .res_idx(res_idx),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] exp_idx(input logic [5:0] a, input logic tx);
    logic [5:0] v;
    v = a * 6'd7 + 6'd5;
    if (tx) v = v ^ 6'h2A;
    return v;
  endfunction

  // Coordinate table: x = addr*128, y = ~x, one cycle after the read strobe
  always @(posedge clk) begin
    if (coord_rd) begin
      coord_x <= {3'b000, coord_addr, 7'b0};
      coord_y <= ~{3'b000, coord_addr, 7'b0};
    end
  end

  // Phase calculator: fixed PC_LAT latency, drops the drop_k-th start of a beam if set
  logic [PC_LAT-1:0] lat_v;
  logic [5:0]        lat_i [PC_LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_v <= '0;
    end else begin
      lat_v    <= {lat_v[PC_LAT-2:0], pc_start && !(drop_k != 0 && st_n == drop_k)};
      lat_i[0] <= exp_idx(pc_x[12:7], pc_is_tx);
      for (int i = 1; i < PC_LAT; i++) lat_i[i] <= lat_i[i-1];
    end
  end
  assign pc_valid     = lat_v[PC_LAT-1] | spur_v;
  assign pc_phase_idx = lat_v[PC_LAT-1] ? lat_i[PC_LAT-1] : 6'h3F;

  // Event recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (coord_rd) begin
        if (coord_addr !== 6'(rd_n)) rd_bad++;
        if (rd_n == 0) rd_first = cyc;
        rd_last = cyc;
        rd_n++;
      end
      if (pc_start) begin
        if (pc_x !== 16'(st_n * 128) || pc_y !== ~16'(st_n * 128)) st_bad++;
        if (st_n == 0) st_first = cyc;
        st_last = cyc;
        st_n++;
      end
      if (res_we) begin
        res_mem[res_addr]  = res_idx;
        res_mask[res_addr] = 1'b1;
        we_n++;
        we_last = cyc;
      end
      if (done) begin done_n++; done_cyc = cyc; end
      if (err_timeout) begin err_n++; err_cyc = cyc; end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_n = 0; rd_first = -1; rd_last = -1; rd_bad = 0;
    st_n = 0; st_first = -1; st_last = -1; st_bad = 0;
    we_n = 0; we_last = -1; done_n = 0; done_cyc = -1; err_n = 0; err_cyc = -1;
    res_mask = '0;
  endtask

  // Presents one command in the current cycle (accepted at its closing edge)
  task automatic issue_cmd(input int n, input logic tx, input logic [15:0] az,
                           input logic [15:0] el, output int t);
    cmd_n_elem = 7'(n); cmd_is_tx = tx; cmd_az_deg = az; cmd_el_deg = el;
    cmd_valid = 1'b1;
    t = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    step();
    vecs++; if ({coord_rd, pc_start, res_we, done, err_timeout} !== 5'b0) begin
      errs++; $display("FAIL reset_strobes: got %b want 00000", {coord_rd, pc_start, res_we, done, err_timeout}); end
    vecs++; if ({pc_az, pc_el, pc_is_tx} !== 33'b0) begin
      errs++; $display("FAIL reset_latched: got %h want 0", {pc_az, pc_el, pc_is_tx}); end
  endtask

  task automatic test_basic();
    int t;
    clear_logs(); drop_k = 0;
    issue_cmd(4, 1'b1, 16'h1234, 16'hFE80, t);
    vecs++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errs++; $display("FAIL basic_busy: got busy=%b ready=%b want 1/0", busy, cmd_ready); end
    spur_v = 1'b1; step(); spur_v = 1'b0;
    vecs++; if ({pc_az, pc_el, pc_is_tx} !== {16'h1234, 16'hFE80, 1'b1}) begin
      errs++; $display("FAIL basic_latch: got %h %h %b want 1234 fe80 1", pc_az, pc_el, pc_is_tx); end
    for (int i = 0; i < 200 && done_n == 0; i++) step();
    step();
    vecs++; if (rd_n !== 4 || rd_first !== t + 1 || rd_last !== t + 4 || rd_bad !== 0) begin
      errs++; $display("FAIL basic_reads: got n=%0d %0d..%0d bad=%0d want 4 %0d..%0d 0", rd_n, rd_first, rd_last, rd_bad, t + 1, t + 4); end
    vecs++; if (st_n !== 4 || st_first !== t + 2 || st_last !== t + 5 || st_bad !== 0) begin
      errs++; $display("FAIL basic_starts: got n=%0d %0d..%0d bad=%0d want 4 %0d..%0d 0", st_n, st_first, st_last, st_bad, t + 2, t + 5); end
    vecs++; if (we_n !== 4 || res_mask !== 64'hF || we_last !== t + 38) begin
      errs++; $display("FAIL basic_writes: got n=%0d mask=%h last=%0d want 4 f %0d", we_n, res_mask, we_last, t + 38); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if (res_mem[i] !== exp_idx(6'(i), 1'b1)) begin
        errs++; $display("FAIL basic_data[%0d]: got %h want %h", i, res_mem[i], exp_idx(6'(i), 1'b1)); end
    end
    vecs++; if (done_n !== 1 || done_cyc !== t + 39) begin
      errs++; $display("FAIL basic_done: got n=%0d at %0d want 1 at %0d", done_n, done_cyc, t + 39); end
  endtask

  task automatic test_zero();
    int t;
    clear_logs();
    issue_cmd(0, 1'b0, 16'h0100, 16'h0200, t);
    vecs++; if (done !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL zero_t1: got done=%b busy=%b want 0/1", done, busy); end
    step();
    vecs++; if (done !== 1'b1 || cmd_ready !== 1'b0) begin
      errs++; $display("FAIL zero_t2: got done=%b ready=%b want 1/0", done, cmd_ready); end
    step();
    vecs++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errs++; $display("FAIL zero_t3: got done=%b ready=%b want 0/1", done, cmd_ready); end
    vecs++; if (we_n !== 0 || rd_n !== 0 || st_n !== 0) begin
      errs++; $display("FAIL zero_activity: got we=%0d rd=%0d st=%0d want 0", we_n, rd_n, st_n); end
  endtask

  task automatic test_saturate();
    int t;
    clear_logs();
    issue_cmd(100, 1'b0, 16'h0001, 16'h0002, t);
    for (int i = 0; i < 300 && done_n == 0; i++) step();
    step();
    vecs++; if (rd_n !== 64 || rd_last !== t + 64 || rd_bad !== 0) begin
      errs++; $display("FAIL sat_reads: got n=%0d last=%0d bad=%0d want 64 %0d 0", rd_n, rd_last, rd_bad, t + 64); end
    vecs++; if (we_n !== 64 || res_mask !== '1) begin
      errs++; $display("FAIL sat_writes: got n=%0d mask=%h want 64 all", we_n, res_mask); end
    vecs++; if (res_mem[63] !== exp_idx(6'd63, 1'b0) || res_mem[0] !== exp_idx(6'd0, 1'b0)) begin
      errs++; $display("FAIL sat_data: got %h %h want %h %h", res_mem[0], res_mem[63], exp_idx(6'd0, 1'b0), exp_idx(6'd63, 1'b0)); end
    vecs++; if (done_n !== 1 || done_cyc !== t + 99) begin
      errs++; $display("FAIL sat_done: got n=%0d at %0d want 1 at %0d", done_n, done_cyc, t + 99); end
  endtask

  task automatic test_timeout();
    int t, idle_c;
    clear_logs(); drop_k = 3;
    issue_cmd(4, 1'b0, 16'h0A00, 16'h0B00, t);
    for (int i = 0; i < 300 && err_n == 0; i++) step();
    vecs++; if (err_cyc !== t + 79) begin
      errs++; $display("FAIL timeout_cycle: got %0d want %0d", err_cyc, t + 79); end
    for (int i = 0; i < 300 && busy; i++) step();
    idle_c = cyc;
    drop_k = 0;
    vecs++; if (idle_c !== t + 113) begin
      errs++; $display("FAIL timeout_flush_len: idle at %0d want %0d", idle_c, t + 113); end
    vecs++; if (err_n !== 1 || done_n !== 0) begin
      errs++; $display("FAIL timeout_flags: got err=%0d done=%0d want 1 0", err_n, done_n); end
    vecs++; if (we_n !== 3 || res_mask !== 64'h7 || res_mem[2] !== exp_idx(6'd3, 1'b0)) begin
      errs++; $display("FAIL timeout_writes: got n=%0d mask=%h d2=%h want 3 7 %h", we_n, res_mask, res_mem[2], exp_idx(6'd3, 1'b0)); end
  endtask

  task automatic test_abort();
    int t, idle_c;
    clear_logs();
    issue_cmd(16, 1'b1, 16'h2222, 16'h3333, t);
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    vecs++; if (coord_rd !== 1'b0 || pc_start !== 1'b0) begin
      errs++; $display("FAIL abort_drop: got rd=%b start=%b want 0 0", coord_rd, pc_start); end
    for (int i = 0; i < 300 && busy; i++) step();
    idle_c = cyc;
    vecs++; if (idle_c !== t + 41) begin
      errs++; $display("FAIL abort_flush_len: idle at %0d want %0d", idle_c, t + 41); end
    vecs++; if (st_n !== 5 || st_last !== t + 6 || rd_n !== 6) begin
      errs++; $display("FAIL abort_issue: got st=%0d last=%0d rd=%0d want 5 %0d 6", st_n, st_last, rd_n, t + 6); end
    vecs++; if (we_n !== 0 || done_n !== 0 || err_n !== 0) begin
      errs++; $display("FAIL abort_quiet: got we=%0d done=%0d err=%0d want 0 0 0", we_n, done_n, err_n); end
    clear_logs();
    issue_cmd(2, 1'b0, 16'h0000, 16'h0000, t);
    for (int i = 0; i < 200 && done_n == 0; i++) step();
    step();
    vecs++; if (we_n !== 2 || res_mask !== 64'h3) begin
      errs++; $display("FAIL abort_next_writes: got n=%0d mask=%h want 2 3", we_n, res_mask); end
    vecs++; if (res_mem[0] !== exp_idx(6'd0, 1'b0) || res_mem[1] !== exp_idx(6'd1, 1'b0)) begin
      errs++; $display("FAIL abort_next_data: got %h %h want %h %h", res_mem[0], res_mem[1], exp_idx(6'd0, 1'b0), exp_idx(6'd1, 1'b0)); end
    vecs++; if (done_cyc !== t + 37) begin
      errs++; $display("FAIL abort_next_done: got %0d want %0d", done_cyc, t + 37); end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    clear_logs();
    cmd_n_elem = 7'd3; cmd_is_tx = 1'b0; cmd_az_deg = 16'h0400; cmd_el_deg = 16'h0500;
    cmd_valid = 1'b1;
    t1 = cyc;
    step();
    cmd_is_tx = 1'b1;
    t2 = -1;
    for (int i = 0; i < 200 && t2 < 0; i++) begin
      if (cmd_ready) t2 = cyc;
      else step();
    end
    spur_v = 1'b1;
    step();
    cmd_valid = 1'b0; spur_v = 1'b0;
    vecs++; if (t2 !== t1 + 39) begin
      errs++; $display("FAIL b2b_accept: second accept at %0d want %0d", t2, t1 + 39); end
    for (int i = 0; i < 200 && done_n < 2; i++) step();
    spur_v = 1'b1;
    repeat (3) step();
    spur_v = 1'b0;
    step();
    vecs++; if (done_n !== 2 || done_cyc !== t2 + 38) begin
      errs++; $display("FAIL b2b_done: got n=%0d at %0d want 2 at %0d", done_n, done_cyc, t2 + 38); end
    vecs++; if (we_n !== 6 || res_mask !== 64'h7) begin
      errs++; $display("FAIL b2b_writes: got n=%0d mask=%h want 6 7", we_n, res_mask); end
    for (int i = 0; i < 3; i++) begin
      vecs++; if (res_mem[i] !== exp_idx(6'(i), 1'b1)) begin
        errs++; $display("FAIL b2b_data[%0d]: got %h want %h", i, res_mem[i], exp_idx(6'(i), 1'b1)); end
    end
  endtask

  task automatic test_mid_reset();
    int t;
    clear_logs();
    issue_cmd(8, 1'b1, 16'h7777, 16'h6666, t);
    repeat (4) step();
    rst = 1'b1;
    #1;
    vecs++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || coord_rd !== 1'b0 || pc_start !== 1'b0) begin
      errs++; $display("FAIL midrst_ctrl: got busy=%b ready=%b rd=%b start=%b want 0 1 0 0", busy, cmd_ready, coord_rd, pc_start); end
    vecs++; if (pc_az !== 16'h0 || pc_is_tx !== 1'b0) begin
      errs++; $display("FAIL midrst_latch: got az=%h tx=%b want 0 0", pc_az, pc_is_tx); end
    step();
    rst = 1'b0;
    clear_logs();
    repeat (50) step();
    vecs++; if (we_n !== 0 || done_n !== 0 || rd_n !== 0) begin
      errs++; $display("FAIL midrst_quiet: got we=%0d done=%0d rd=%0d want 0 0 0", we_n, done_n, rd_n); end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_zero();
    test_saturate();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
